// File: rtl/simple_multiplier.sv
// Sequential radix-2 shift-add multiplier: one partial product per cycle, start_i/ready_o level handshake.
// Define MUL_SIGNED_EN to add the signed_i port and two's-complement operand/result handling.
module simple_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic [WIDTH-1:0]     multiplier_i,
`ifdef MUL_SIGNED_EN
    input  logic                 signed_i,
`endif
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 neg_q, neg_d;

    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 op_neg;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   raw_p;

    // Operand conditioning at accept time: magnitudes plus a result-sign flag.
    always_comb begin
`ifdef MUL_SIGNED_EN
        op_a   = (signed_i && multiplicand_i[WIDTH-1]) ? -multiplicand_i : multiplicand_i;
        op_b   = (signed_i && multiplier_i[WIDTH-1])   ? -multiplier_i   : multiplier_i;
        op_neg = signed_i & (multiplicand_i[WIDTH-1] ^ multiplier_i[WIDTH-1]);
`else
        op_a   = multiplicand_i;
        op_b   = multiplier_i;
        op_neg = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        neg_d     = neg_q;
        sum       = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        raw_p     = {acc_q[WIDTH-1:0], mplier_q};

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    neg_d    = op_neg;
                    acc_d    = '0;
                    count_d  = CW'(WIDTH);
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (count_q != '0) begin
                    // Consumed multiplier bits fall off the bottom as product bits enter the top.
                    acc_d    = {1'b0, sum[WIDTH:1]};
                    mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                    count_d  = count_q - CW'(1);
                end else begin
`ifdef MUL_SIGNED_EN
                    product_d = neg_q ? -raw_p : raw_p;
`else
                    product_d = raw_p;
`endif
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (!start_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
            neg_q     <= neg_d;
        end
    end

    assign product_o = product_q;
    assign ready_o   = (state_q == DONE);
    assign busy_o    = (state_q == CALC);

`ifndef MUL_SIGNED_EN
    logic unused_neg;
    assign unused_neg = neg_q;
`endif

endmodule

// File: tb/tb_simple_multiplier.sv
// Bench for simple_multiplier at WIDTH=32 and WIDTH=8: directed table, handshake corner sequences, random ops.
`timescale 1ns/1ps
module tb_simple_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sgn;
  logic [31:0] a, b;
  logic [63:0] prod;
  logic        ready, busy;
  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        ready8, busy8;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  simple_multiplier #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .multiplicand_i(a), .multiplier_i(b),
`ifdef MUL_SIGNED_EN
    .signed_i(sgn),
`endif
    .product_o(prod), .ready_o(ready), .busy_o(busy)
  );

  simple_multiplier #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8),
    .multiplicand_i(a8), .multiplier_i(b8),
`ifdef MUL_SIGNED_EN
    .signed_i(sgn8),
`endif
    .product_o(prod8), .ready_o(ready8), .busy_o(busy8)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx, sy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (s) return sx * sy;
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic signed [15:0] sx, sy;
    sx = {{8{x[7]}}, x};
    sy = {{8{y[7]}}, y};
    if (s) return sx * sy;
    return {8'b0, x} * {8'b0, y};
  endfunction

  // lat = rising edges after the accepting edge until ready_o is seen; bcnt = cycles busy_o was high.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic os,
                        input bit perturb, input bit hold,
                        output logic [63:0] p, output int lat, output int bcnt);
    @(negedge clk);
    a = oa; b = ob; sgn = os; start = 1'b1;
    @(posedge clk);
    lat = 0; bcnt = 0;
    @(negedge clk);
    if (busy) bcnt++;
    while (!ready && lat < 200) begin
      if (perturb) begin
        a = $urandom; b = $urandom;
        start = 1'($urandom_range(0, 1));
        sgn = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (busy) bcnt++;
    end
    p = prod;
    if (!hold) start = 1'b0;
  endtask

  task automatic run_op8(input logic [7:0] oa, input logic [7:0] ob, input logic os,
                         output logic [15:0] p, output int lat);
    @(negedge clk);
    a8 = oa; b8 = ob; sgn8 = os; start8 = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    a8 = $urandom; b8 = $urandom;
    while (!ready8 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    p = prod8;
    start8 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    logic [15:0] p8;
    logic [63:0] e;
    logic [31:0] ra, rb;
    logic [7:0]  ra8, rb8;
    logic        rs;
    int lat, bcnt, bad;

    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "max_x_max"});
    vecs.push_back('{32'h0000_0000, 32'h0000_1234, 1'b0, 64'h0, "zero_a"});
    vecs.push_back('{32'h0000_0001, 32'hDEAD_BEEF, 1'b0, 64'h0000_0000_DEAD_BEEF, "one_x_deadbeef"});
    vecs.push_back('{32'h1234_5678, 32'h0000_0000, 1'b0, 64'h0, "zero_b"});
    vecs.push_back('{32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000, "carry_into_high"});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0000_0000_FFFF_FFFF, "max_x_one"});
    vecs.push_back('{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, "pow2_square"});
    vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 64'h0000_0006_FFFF_FFEB, "unsigned_neg3_x_7"});
`ifdef MUL_SIGNED_EN
    vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "signed_neg3_x_7"});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "signed_minneg_sq"});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, "signed_minneg_x_1"});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "signed_m1_x_m1"});
`endif

    // Reset state
    rst = 1'b1; start = 1'b0; start8 = 1'b0; sgn = 1'b0; sgn8 = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    #1;
    check("reset_product", prod, 64'h0);
    check("reset_ready", {63'b0, ready}, 64'h0);
    check("reset_busy", {63'b0, busy}, 64'h0);
    check("reset_product8", {48'b0, prod8}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, 1'b0, p, lat, bcnt);
      check(vecs[i].name, p, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd33);
      check({vecs[i].name, "_busy_cycles"}, 64'(bcnt), 64'd33);
    end

    // Held start: a single operation, ready and product stay put
    run_op(32'h10, 32'h20, 1'b0, 1'b0, 1'b1, p, lat, bcnt);
    check("held_first_result", p, 64'h200);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      if (!ready || busy || prod !== 64'h200) bad++;
    end
    check("held_start_stable", 64'(bad), 64'd0);
    start = 1'b0;
    run_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, p, lat, bcnt);
    check("relaunch_3x5", p, 64'h0F);
    check("relaunch_latency", 64'(lat), 64'd33);

    // Reset in the middle of CALC
    @(negedge clk);
    a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("midcalc_busy", {63'b0, busy}, 64'h1);
    rst = 1'b1;
    #1;
    check("midcalc_rst_ready", {63'b0, ready}, 64'h0);
    check("midcalc_rst_busy", {63'b0, busy}, 64'h0);
    check("midcalc_rst_product", prod, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd2, 32'd3, 1'b0, 1'b0, 1'b0, p, lat, bcnt);
    check("after_reset_2x3", p, 64'h6);
    check("after_reset_latency", 64'(lat), 64'd33);

    // Operand and start changes during CALC must be ignored
    run_op(32'h0BAD_F00D, 32'h1357_9BDF, 1'b0, 1'b1, 1'b0, p, lat, bcnt);
    check("perturbed_result", p, model32(32'h0BAD_F00D, 32'h1357_9BDF, 1'b0));
    check("perturbed_latency", 64'(lat), 64'd33);

    // Random ops at WIDTH=32, scoreboarded against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ;
      endcase
`ifdef MUL_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      exp_q.push_back(model32(ra, rb, rs));
      run_op(ra, rb, rs, ($urandom_range(0, 3) == 0), 1'b0, p, lat, bcnt);
      e = exp_q.pop_front();
      check($sformatf("rand32_%0d a=%0h b=%0h s=%0b", i, ra, rb, rs), p, e);
      check($sformatf("rand32_%0d_latency", i), 64'(lat), 64'd33);
    end

    // Random ops at WIDTH=8
    run_op8(8'hFF, 8'hFF, 1'b0, p8, lat);
    check("w8_max_x_max", {48'b0, p8}, 64'hFE01);
    check("w8_latency", 64'(lat), 64'd9);
    for (int i = 0; i < 1000; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom);
`ifdef MUL_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      exp_q.push_back({48'b0, model8(ra8, rb8, rs)});
      run_op8(ra8, rb8, rs, p8, lat);
      e = exp_q.pop_front();
      check($sformatf("rand8_%0d a=%0h b=%0h s=%0b", i, ra8, rb8, rs), {48'b0, p8}, e);
      check($sformatf("rand8_%0d_latency", i), 64'(lat), 64'd9);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
